parity_stream_checker: RTL and testbench
========================================

// Module: parity_stream_checker
// PURPOSE
//  Streaming parity generator/checker for a DATA_W-bit word bus with valid/ready handshake.
//  Per beat it generates the parity bit, checks a received parity bit, and keeps a running
//  block parity across a frame delimited by in_last. Sits between the byte source and the
//  serial framer; replaces the combinational 8-bit parity generator on clocked datapaths.
// PARAMETERS
//  DATA_W  8  width of in_data/out_data, >=1
//  CNT_W   8  width of err_count, saturating counter (PARITY_ERR_CNT_EN only)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  parity_type  in   2       01 odd, 10 even, 00/11 disabled (mark); sampled on accept
//  in_valid     in   1       input beat valid
//  in_ready     out  1       block can accept input beat
//  in_data      in   DATA_W  input word
//  in_parity    in   1       received parity bit to check against
//  in_last      in   1       last beat of frame
//  out_valid    out  1       output beat valid
//  out_ready    in   1       downstream accepts output beat
//  out_data     out  DATA_W  registered copy of accepted in_data
//  out_parity   out  1       generated parity for out_data
//  out_err      out  1       in_parity mismatched generated parity on this beat
//  out_last     out  1       registered in_last
//  out_blk_par  out  1       running block parity (XOR of all out_parity in frame), valid with out_last
//  err_sticky   out  1       set by any beat with out_err, held until clr_err
//  clr_err      in   1       synchronous clear of err_sticky (and err_count)
//  err_count    out  CNT_W   beats with out_err, saturating (only if PARITY_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_data=0, out_parity=1, out_err=0, out_last=0,
//    out_blk_par=0, err_sticky=0, err_count=0, block accumulator=0. in_ready=1 after release.
//  - Accept: in_valid & in_ready at posedge. in_ready = !out_valid | out_ready (one-entry stage,
//    full throughput, no combinational in_valid->out_valid path). Latency 1 cycle.
//  - Hold: out_valid & !out_ready -> all out_* stable; no new beat accepted.
//  - Parity: p = ^in_data. Odd: out_parity = ~p (total ones odd). Even: out_parity = p.
//    Disabled (00/11): out_parity=1, out_err=0, beat excluded from err_sticky/err_count.
//  - Check: out_err = (in_parity != generated parity) for odd/even modes.
//  - Block accumulator: acc ^= generated parity per accepted beat; out_blk_par = acc incl. current
//    beat. Beat with in_last: acc cleared to 0 for next frame. Frame of one beat: out_blk_par=out_parity.
//  - parity_type changes mid-frame: each beat uses its own sampled type; accumulator not reset.
//  - err_sticky: set on accept of an erroring beat (visible with that out_valid); clr_err in same cycle
//    as new error -> set wins. clr_err with no error -> cleared next cycle.
//  - No accept while out_valid & !out_ready: pending in_valid waits, counters untouched.
//  - Reset mid-frame: beat in stage dropped, accumulator and errors cleared.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined: err_count port present; increments by 1 per accepted erroring beat,
//    saturates at 2**CNT_W-1; clr_err zeroes it (clear and error same cycle -> 1).
//  Not defined: err_count port and counter logic absent; all other behaviour identical.
// TESTING
//  1 reset=0, in_valid=1 -> out_valid=0, out_parity=1, in_ready=1; after release idle, no accept effects.
//  2 odd, in_data=8'h00, in_parity=1 -> next cycle out_parity=1, out_err=0; in_data=8'h01,in_parity=1 -> out_parity=0,out_err=1,err_sticky=1.
//  3 even, data 8'h01,8'h03,8'h07(last), correct in_parity -> out_parity 1,0,1; out_blk_par on last=0; no errors.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable; out_ready=1 -> one beat per cycle, none lost/duplicated.
//  5 parity_type=00, in_parity=0 -> out_parity=1, out_err=0, err_sticky unchanged; clr_err with error same cycle -> err_sticky=1.
//  6 PARITY_ERR_CNT_EN, CNT_W=2: 5 erroring beats -> err_count 1,2,3,3,3; clr_err -> 0; reset mid-frame clears acc (next out_blk_par restarts).

Source files
------------

// File: rtl/parity_stream_if.sv
// parity_stream_if: valid/ready word stream carrying a received parity bit in and
// generated parity, check result, frame end and block parity out.
interface parity_stream_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_parity;
  logic              out_err;
  logic              out_last;
  logic              out_blk_par;
  modport slave (
    input  in_valid, in_data, in_parity, in_last, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_err, out_last, out_blk_par
  );
  modport master (
    output in_valid, in_data, in_parity, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_err, out_last, out_blk_par
  );
endinterface

// File: rtl/parity_stream_checker.sv
// parity_stream_checker: one-stage parity generator/checker with running block parity.
// Define PARITY_ERR_CNT_EN to add the saturating err_count output (width CNT_W).
module parity_stream_checker #(
  parameter int DATA_W = 8
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     parity_type,
  input  logic           clr_err,
  output logic           err_sticky,
  parity_stream_if.slave s
`ifdef PARITY_ERR_CNT_EN
  , output logic [CNT_W-1:0] err_count
`endif
);
  logic              accept, odd, even, gen, err, blk;
  logic              valid_q, valid_d, par_q, par_d, err_q, err_d, last_q, last_d;
  logic              blk_q, blk_d, acc_q, acc_d, sticky_q, sticky_d;
  logic [DATA_W-1:0] data_q, data_d;
  assign s.in_ready = !valid_q | s.out_ready;
  assign accept     = s.in_valid & s.in_ready;
  assign odd        = parity_type == 2'b01;
  assign even       = parity_type == 2'b10;
  // disabled modes emit a mark bit and never flag an error
  assign gen        = odd ? ~^s.in_data : even ? ^s.in_data : 1'b1;
  assign err        = (odd | even) & (s.in_parity != gen);
  assign blk        = acc_q ^ gen;
  always_comb begin
    valid_d  = accept ? 1'b1 : s.out_ready ? 1'b0 : valid_q;
    data_d   = accept ? s.in_data : data_q;
    par_d    = accept ? gen : par_q;
    err_d    = accept ? err : err_q;
    last_d   = accept ? s.in_last : last_q;
    blk_d    = accept ? blk : blk_q;
    acc_d    = accept ? (s.in_last ? 1'b0 : blk) : acc_q;
    sticky_d = (accept & err) ? 1'b1 : clr_err ? 1'b0 : sticky_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b1;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
      blk_q    <= 1'b0;
      acc_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      par_q    <= par_d;
      err_q    <= err_d;
      last_q   <= last_d;
      blk_q    <= blk_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end
  assign s.out_valid   = valid_q;
  assign s.out_data    = data_q;
  assign s.out_parity  = par_q;
  assign s.out_err     = err_q;
  assign s.out_last    = last_q;
  assign s.out_blk_par = blk_q;
  assign err_sticky    = sticky_q;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // an error arriving with clr_err restarts the count at one
  always_comb
    cnt_d = (accept & err) ? (clr_err ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1))
          : clr_err ? '0 : cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker: table-driven vectors through a scoreboard queue, plus
// hand sequences for backpressure, sticky clear, mid-frame reset and the error counter.
module tb_parity_stream_checker;
  typedef struct {
    logic [1:0] pt;
    logic [7:0] data;
    logic       par;
    logic       last;
    logic       e_par;
    logic       e_err;
    logic       e_blk;
    logic       e_sticky;
  } vec_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] parity_type;
  logic       clr_err;
  logic       err_sticky;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0] err_count;
`endif
  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t tbl[10];
  parity_stream_if #(.DATA_W(8)) bus();
  parity_stream_checker #(
    .DATA_W(8)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .parity_type(parity_type),
    .clr_err(clr_err),
    .err_sticky(err_sticky),
    .s(bus)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      vec_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got data %0h want none", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_parity", bus.out_parity, e.e_par);
        chk("out_err", bus.out_err, e.e_err);
        chk("out_last", bus.out_last, e.last);
        chk("out_blk_par", bus.out_blk_par, e.e_blk);
        chk("err_sticky", err_sticky, e.e_sticky);
      end
    end
  end
  task automatic drive(vec_t v);
    int n = 0;
    bus.in_valid = 1'b1;
    parity_type = v.pt;
    bus.in_data = v.data;
    bus.in_parity = v.par;
    bus.in_last = v.last;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (++n > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got in_ready 0 want 1");
        bus.in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(v);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2'b01, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{2'b10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{2'b10, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{2'b10, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{2'b00, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{2'b11, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{2'b01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{2'b10, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{2'b01, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    parity_type = 2'b01;
    clr_err = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    bus.in_parity = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_parity", bus.out_parity, 1);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_blk_par", bus.out_blk_par, 0);
    chk("rst_err_sticky", err_sticky, 0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 10; i++) drive(tbl[i]);
    drain();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("clr_sticky", err_sticky, 0);
    drive('{2'b00, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    drain();
    chk("disabled_sticky", err_sticky, 0);
    clr_err = 1'b1;
    drive('{2'b01, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    clr_err = 1'b0;
    drain();
    chk("clr_vs_err_sticky", err_sticky, 1);
    bus.out_ready = 1'b0;
    drive('{2'b10, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    bus.in_valid = 1'b1;
    bus.in_data = 8'h13;
    bus.in_parity = 1'b1;
    bus.in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 8'h11);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    sb.push_back('{2'b10, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();
    drive('{2'b10, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    reset = 1'b0;
    sb.delete();
    #2;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_parity", bus.out_parity, 1);
    chk("midrst_blk_par", bus.out_blk_par, 0);
    chk("midrst_sticky", err_sticky, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    drive('{2'b10, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    drain();
`ifdef PARITY_ERR_CNT_EN
    chk("cnt_start", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      drive('{2'b01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      chk("cnt_sat", err_count, (i < 3) ? i + 1 : 3);
    end
    drain();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("cnt_clr", err_count, 0);
    clr_err = 1'b1;
    drive('{2'b01, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    clr_err = 1'b0;
    chk("cnt_clr_vs_err", err_count, 1);
    drain();
`endif
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
